// File: rtl/serdes_pkg.sv
// Shared constants and types for the comma-aligned serial receive front end.
package serdes_pkg;

    localparam int SYM_W = 10;
    localparam int PH_W  = $clog2(SYM_W);

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;

    function automatic logic is_comma(input logic [SYM_W-1:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

endpackage

// File: rtl/serdes_rx_lane_align.sv
// One lane: bit window, symbol phase, HUNT/VERIFY/LOCKED tracking and
// registered aligned-symbol output.
module serdes_rx_lane_align
    import serdes_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_ERRS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic             sym_comma,
    output logic             locked
);

    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    localparam logic [CW-1:0]   CNT_LOCK = CW'(LOCK_COMMAS);
    localparam logic [EW-1:0]   ERR_LOSS = EW'(LOSS_ERRS);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SYM_W - 1);

    logic [SYM_W-1:0] window;
    logic [PH_W-1:0]  phase, phase_nxt;
    align_state_t     state, state_nxt;
    logic [CW-1:0]    comma_cnt, cnt_nxt;
    logic [EW-1:0]    err_cnt, err_nxt;
    logic [SYM_W-1:0] sym_nxt;
    logic             valid_nxt, comma_nxt;
    logic             match, boundary;

    assign match    = is_comma(window);
    assign boundary = (phase == '0);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
        cnt_nxt   = comma_cnt;
        err_nxt   = err_cnt;
        sym_nxt   = sym;
        valid_nxt = 1'b0;
        comma_nxt = 1'b0;
        case (state)
            HUNT: begin
                if (match) begin
                    // Current cycle becomes phase 0, so the next one is phase 1.
                    phase_nxt = PH_W'(1);
                    cnt_nxt   = CW'(1);
                    err_nxt   = '0;
                    state_nxt = (CNT_LOCK <= CW'(1)) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (match && boundary) begin
                    if (comma_cnt != CNT_LOCK) cnt_nxt = comma_cnt + 1'b1;
                    if (cnt_nxt == CNT_LOCK) begin
                        state_nxt = LOCKED;
                        err_nxt   = '0;
                    end
                end else if (match) begin
                    phase_nxt = PH_W'(1);
                    cnt_nxt   = CW'(1);
                end
            end
            LOCKED: begin
                if (boundary) begin
                    sym_nxt   = window;
                    valid_nxt = 1'b1;
                    comma_nxt = match;
                end
                if (match && boundary) begin
                    err_nxt = '0;
                end else if (match) begin
                    // Stray comma: count it but keep the established phase.
                    if (err_cnt != ERR_LOSS) err_nxt = err_cnt + 1'b1;
                    if (err_nxt == ERR_LOSS) begin
                        state_nxt = HUNT;
                        cnt_nxt   = '0;
                        err_nxt   = '0;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            phase     <= '0;
            state     <= HUNT;
            comma_cnt <= '0;
            err_cnt   <= '0;
            sym       <= '0;
            sym_valid <= 1'b0;
            sym_comma <= 1'b0;
        end else begin
            window    <= {window[SYM_W-2:0], ser};
            phase     <= phase_nxt;
            state     <= state_nxt;
            comma_cnt <= cnt_nxt;
            err_cnt   <= err_nxt;
            sym       <= sym_nxt;
            sym_valid <= valid_nxt;
            sym_comma <= comma_nxt;
        end
    end

endmodule

// File: rtl/serdes_rx_aligner.sv
// Multi-lane comma-aligned receive front end: independent per-lane aligners
// plus a registered link-up flag.
module serdes_rx_aligner
    import serdes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_ERRS   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       ser_in,
    output logic [LANES*SYM_W-1:0] sym_out,
    output logic [LANES-1:0]       sym_valid,
    output logic [LANES-1:0]       sym_comma,
    output logic [LANES-1:0]       lane_locked,
    output logic                   link_up
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serdes_rx_lane_align #(
            .LOCK_COMMAS (LOCK_COMMAS),
            .LOSS_ERRS   (LOSS_ERRS)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .ser       (ser_in[i]),
            .sym       (sym_out[SYM_W*i +: SYM_W]),
            .sym_valid (sym_valid[i]),
            .sym_comma (sym_comma[i]),
            .locked    (lane_locked[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) link_up <= 1'b0;
        else        link_up <= &lane_locked;
    end

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// Scoreboard bench: per-lane bit streams are built up front, expected symbols
// are sliced from those streams at the lock phase and matched as strobes appear.
module tb_serdes_rx_aligner;

    localparam int LANES = 4;
    localparam int MAXB  = 600;
    localparam logic [9:0] RDN = 10'b0011111010;
    localparam logic [9:0] RDP = 10'b1100000101;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [LANES-1:0]    ser_in;
    logic [LANES*10-1:0] sym_out;
    logic [LANES-1:0]    sym_valid, sym_comma, lane_locked;
    logic                link_up;

    serdes_rx_aligner #(.LANES(LANES), .LOCK_COMMAS(3), .LOSS_ERRS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sym_comma   (sym_comma),
        .lane_locked (lane_locked),
        .link_up     (link_up)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        logic       comma;
        int         e;
    } exp_t;

    exp_t exp_q[LANES][$];
    bit   strm[LANES][MAXB];
    int   pos[LANES];
    int   e_last;
    int   exp_rise[LANES], exp_fall[LANES], obs_rise[LANES], obs_fall[LANES];
    int   exp_link_rise, exp_link_fall, obs_link_rise, obs_link_fall;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_k(input logic [9:0] w);
        return (w == RDN) || (w == RDP);
    endfunction

    // First stream bit of the symbol lands in bit 9.
    function automatic logic [9:0] slice(input int ln, input int l);
        logic [9:0] s;
        for (int k = 0; k < 10; k++) s[9-k] = strm[ln][l-9+k];
        return s;
    endfunction

    task automatic put(input int ln, input logic [9:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            strm[ln][pos[ln]] = w[k];
            pos[ln]++;
        end
    endtask

    task automatic clear_scn();
        for (int ln = 0; ln < LANES; ln++) begin
            pos[ln] = 0;
            for (int b = 0; b < MAXB; b++) strm[ln][b] = 1'b0;
            exp_q[ln].delete();
            exp_rise[ln] = -1;
            exp_fall[ln] = -1;
        end
        exp_link_rise = -1;
        exp_link_fall = -1;
    endtask

    // Locked lane emits the window every 10 bits after the locking comma.
    task automatic expect_syms(input int ln, input int l3, input int lend);
        exp_t x;
        for (int l = l3 + 10; l < lend && l + 1 <= e_last; l += 10) begin
            x.sym   = slice(ln, l);
            x.comma = is_k(x.sym);
            x.e     = l + 1;
            exp_q[ln].push_back(x);
        end
    endtask

    task automatic drive(input int idx);
        for (int ln = 0; ln < LANES; ln++)
            ser_in[ln] = (idx < MAXB) ? strm[ln][idx] : 1'b0;
    endtask

    task automatic monitor(input int e);
        exp_t x;
        for (int ln = 0; ln < LANES; ln++) begin
            if (sym_valid[ln]) begin
                if (exp_q[ln].size() == 0) begin
                    chk($sformatf("L%0d_unexp_valid_e%0d", ln, e), 1, 0);
                end else begin
                    x = exp_q[ln].pop_front();
                    chk($sformatf("L%0d_sym", ln), sym_out[10*ln +: 10], x.sym);
                    chk($sformatf("L%0d_comma", ln), sym_comma[ln], x.comma);
                    chk($sformatf("L%0d_valid_cycle", ln), e, x.e);
                end
            end else if (sym_comma[ln]) begin
                chk($sformatf("L%0d_stray_comma", ln), 1, 0);
            end
            if (lane_locked[ln] && obs_rise[ln] < 0) obs_rise[ln] = e;
            if (!lane_locked[ln] && obs_rise[ln] >= 0 && obs_fall[ln] < 0) obs_fall[ln] = e;
        end
        if (link_up && obs_link_rise < 0) obs_link_rise = e;
        if (!link_up && obs_link_rise >= 0 && obs_link_fall < 0) obs_link_fall = e;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sym_out"}, sym_out, 0);
        chk({tag, "_sym_valid"}, sym_valid, 0);
        chk({tag, "_sym_comma"}, sym_comma, 0);
        chk({tag, "_lane_locked"}, lane_locked, 0);
        chk({tag, "_link_up"}, link_up, 0);
    endtask

    task automatic run(input string name);
        rst_n  = 1'b0;
        ser_in = '0;
        @(negedge clk);
        @(negedge clk);
        check_zero({name, "_rst"});
        for (int ln = 0; ln < LANES; ln++) begin
            obs_rise[ln] = -1;
            obs_fall[ln] = -1;
        end
        obs_link_rise = -1;
        obs_link_fall = -1;
        rst_n = 1'b1;
        drive(0);
        for (int e = 0; e <= e_last; e++) begin
            @(negedge clk);
            monitor(e);
            drive(e + 1);
        end
        for (int ln = 0; ln < LANES; ln++) begin
            chk($sformatf("%s_L%0d_missing_syms", name, ln), exp_q[ln].size(), 0);
            chk($sformatf("%s_L%0d_lock_rise", name, ln), obs_rise[ln], exp_rise[ln]);
            chk($sformatf("%s_L%0d_lock_fall", name, ln), obs_fall[ln], exp_fall[ln]);
        end
        chk({name, "_link_rise"}, obs_link_rise, exp_link_rise);
        chk({name, "_link_fall"}, obs_link_fall, exp_link_fall);
    endtask

    initial begin
        int offs[LANES];
        logic [9:0] w;
        logic r;
        offs = '{0, 3, 5, 9};

        // Lock and per-lane skew: lane i delayed by offs[i] bits.
        clear_scn();
        e_last = 55;
        for (int ln = 0; ln < LANES; ln++) begin
            put(ln, 10'h000, offs[ln]);
            repeat (3) put(ln, RDN, 10);
            put(ln, 10'h2AA, 10);
            put(ln, 10'h155, 10);
            exp_rise[ln] = offs[ln] + 30;
            expect_syms(ln, offs[ln] + 29, MAXB);
        end
        exp_link_rise = 40;
        run("skew");

        // Asynchronous reset mid-operation clears outputs before any edge.
        chk("pre_rst_link_up", link_up, 1);
        chk("pre_rst_sym0", sym_out[9:0], 10'h155);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");

        // Loss of lock on lane0; lane1 recovers via an aligned comma.
        clear_scn();
        e_last = 115;
        repeat (3) put(0, RDN, 10);
        put(0, 10'h2AA, 10);
        put(0, 10'h000, 2);
        repeat (4) put(0, RDN, 10);
        exp_rise[0] = 30;
        exp_fall[0] = 82;
        expect_syms(0, 29, 81);
        repeat (3) put(1, RDN, 10);
        put(1, 10'h2AA, 10);
        put(1, 10'h000, 2);
        repeat (3) put(1, RDN, 10);
        put(1, 10'h000, 8);
        put(1, RDN, 10);
        put(1, 10'h000, 2);
        put(1, RDN, 10);
        exp_rise[1] = 30;
        expect_syms(1, 29, MAXB);
        for (int ln = 2; ln < LANES; ln++) begin
            repeat (3) put(ln, RDN, 10);
            exp_rise[ln] = 30;
            expect_syms(ln, 29, MAXB);
        end
        exp_link_rise = 31;
        exp_link_fall = 83;
        run("loss");

        // Realign during VERIFY: lock only after three commas at the new phase.
        clear_scn();
        e_last = 80;
        repeat (2) put(0, RDN, 10);
        put(0, 10'h000, 4);
        repeat (3) put(0, RDN, 10);
        put(0, 10'h2AA, 10);
        put(0, 10'h155, 10);
        exp_rise[0] = 54;
        expect_syms(0, 53, MAXB);
        run("realign");

        // Pseudo-random bits with every comma match suppressed.
        clear_scn();
        e_last = 499;
        for (int ln = 0; ln < LANES; ln++) begin
            w = '0;
            for (int b = 0; b < 500; b++) begin
                r = 1'($urandom_range(0, 1));
                if (is_k({w[8:0], r})) r = ~r;
                w = {w[8:0], r};
                strm[ln][b] = r;
            end
        end
        run("nocomma");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_rx_aligner.md
# serdes_rx_aligner

Multi-lane serial receive front end with comma-based word alignment. Sits between the serial input pins and the per-lane SIPO/decoder path. It replaces start-strobe framing with self-synchronising K28.5 comma detection, so the receiver finds 10-bit symbol boundaries on its own. It outputs aligned 10-bit symbols per lane, plus per-lane lock status and a link-up indication.

## Interface
- `LANES`, default 4: number of serial lanes.
- `LOCK_COMMAS`, default 3: aligned commas needed to declare lock.
- `LOSS_ERRS`, default 4: consecutive misaligned commas that drop lock.
- `clk`, in, 1: single receive clock; one serial bit per lane per cycle.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ser_in`, in, LANES: serial bit per lane; bit i = lane i.
- `sym_out`, out, LANES*10: aligned symbol per lane; lane i at [10*i+9:10*i].
- `sym_valid`, out, LANES: one-cycle strobe per lane when that lane's sym_out is new.
- `sym_comma`, out, LANES: qualifies sym_valid; the symbol is K28.5.
- `lane_locked`, out, LANES: lane is in the LOCKED state.
- `link_up`, out, 1: registered AND of all lane_locked.

## Operation
- Bit order: the first received bit of a symbol becomes bit 9.
- Each lane shifts `window <= {window[8:0], ser_in[i]}` every cycle.
- Comma match: the window equals K28_5_RDN (10'b0011111010) or K28_5_RDP (10'b1100000101).
- Each lane has a phase counter, 0..9, wrapping from 9 to 0.
- A boundary is a cycle where the window holds a complete symbol aligned to the current phase.
- Per-lane FSM:
  - HUNT:
    - On a comma match, set phase so a boundary recurs every 10 cycles from this one.
    - Set comma_cnt=1 and go to VERIFY.
    - No sym_valid is produced in HUNT.
  - VERIFY:
    - A comma at a boundary increments comma_cnt.
    - A non-comma at a boundary is accepted and leaves comma_cnt unchanged.
    - A comma at a non-boundary realigns: phase is reset to the new position and comma_cnt=1.
    - When comma_cnt reaches LOCK_COMMAS, go to LOCKED with err_cnt=0.
    - No sym_valid is produced in VERIFY.
  - LOCKED:
    - At every boundary, emit sym_out=window and sym_valid=1, with sym_comma set if the window matches.
    - A comma at a non-boundary increments err_cnt; the phase is not changed.
    - A comma at a boundary clears err_cnt.
    - When err_cnt reaches LOSS_ERRS, go to HUNT and clear the counters.
    - The symbol completed at that same cycle is still emitted if it falls on a boundary.
- Lanes are fully independent. No inter-lane deskew is performed.
- Counter widths are $clog2(LOCK_COMMAS+1) and $clog2(LOSS_ERRS+1); both saturate and never wrap.

## Timing
- Reset (rst_n low, applied asynchronously):
  - window=0, phase=0, every FSM in HUNT, counters 0.
  - sym_out=0, sym_valid=0, sym_comma=0, lane_locked=0, link_up=0.
- Latency: the edge that samples a symbol's last bit completes the window. sym_out, sym_valid and sym_comma are registered at the next edge, so the strobe is visible 1 cycle after the last bit.
- sym_valid period in LOCKED is exactly 10 cycles. It is never asserted in consecutive cycles.
- lane_locked rises in the cycle following the LOCK_COMMAS-th aligned comma's window completion. That comma's own sym_valid is not emitted.
- link_up lags the last lane_locked edge by 1 cycle. It falls 1 cycle after any lane drops lock.
- Reset asserted mid-operation clears all state immediately. The first comma after release restarts HUNT; no partial symbol is emitted.
- Comma detection and boundary in the same cycle while LOCKED counts as aligned (clear err_cnt), not as an error.

## Structure
- `serdes_pkg` holds:
  - the K28_5_RDN and K28_5_RDP constants;
  - the `align_state_t` enum {HUNT, VERIFY, LOCKED};
  - a `SYM_W=10` constant.
- Sub-module `serdes_rx_lane_align` contains one lane: window, phase, FSM, counters and registered outputs.
- The top level generates LANES instances and the link_up register.

## Test plan
- Reset: drive rst_n low mid-stream → every output reads 0 within the same cycle. After release, with no commas sent, sym_valid stays 0 for 100 cycles.
- Lock: lane0 receives 3× K28_5_RDN back-to-back, then 10'h2AA, then 10'h155.
  - lane_locked[0] rises 1 cycle after the third comma completes.
  - sym_out lane0 = 10'h2AA, then 10'h155, each with a one-cycle sym_valid spaced 10 cycles apart and sym_comma=0.
- Per-lane skew: lanes 0..3 start the same comma stream with bit offsets 0, 3, 5, 9.
  - Each lane locks independently.
  - link_up rises 1 cycle after lane3's lane_locked.
- No commas: 500 cycles of a pseudo-random stream with all comma matches filtered out → all lanes remain in HUNT, with sym_valid=0 and link_up=0.
- Loss of lock: after lock, inject 4 commas shifted by 2 bits → lane_locked drops after the 4th.
  - Variant: 3 misaligned commas followed by 1 aligned comma → err_cnt clears and the lane stays locked.
- Realign in VERIFY: 2 aligned commas, then a comma shifted by 4 bits, then 2 more commas at the new alignment → lock is declared at the new phase after the third comma in the new alignment.
